// File: rtl/bias_weight_store.sv
// Double-buffered weight/bias store: updates land in a shadow bank and are committed
// to the active bank only while no forward sample is in flight. Optional macro: BWS_CLIP_EN.
module bias_weight_store #(
    parameter int NP   = 4,
    parameter int NC   = 4,
    parameter int WD   = 8,
    parameter int WS   = 3,
    parameter int WV   = 8,
    parameter int CLIP = 127
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iMode,
    input  logic                        iValid_AS,
    output logic                        oReady_AS,
    input  logic [NC*NP*WD+NC*WD-1:0]   iData_AS,
    input  logic                        iStart,
    input  logic                        iDone,
    output logic [NC*NP*WD+NC*WD-1:0]   oParam,
    output logic [WV-1:0]               oVersion,
    output logic                        oErr
);

    localparam int PW = NC*NP*WD + NC*WD;
    localparam int NW = NC*NP;

    typedef enum logic {IDLE, PEND} state_t;

    if (CLIP < 1 || CLIP > (2**(WD-1)) - 1) begin : gClipRange
        $error("CLIP out of range for WD");
    end

    state_t         state, stateNext;
    logic [PW-1:0]  shadowBank;
    logic [PW-1:0]  activeBank;
    logic [PW-1:0]  commitBank;
    logic [WS-1:0]  cnt, cntNext;
    logic [WV-1:0]  version;
    logic           err;
    logic           errSet;
    logic           commit;
    logic           transfer;
    logic           loadShadow;

    assign commit    = (state == PEND) && (cnt == '0) && !iStart;
    assign oReady_AS = iMode && !iRST && ((state == IDLE) || commit);
    assign transfer  = iValid_AS && oReady_AS;

    assign oParam   = activeBank;
    assign oVersion = version;
    assign oErr     = err;

    // Simultaneous start/done cancel; out-of-range moves are dropped and flagged.
    always_comb begin
        cntNext = cnt;
        errSet  = 1'b0;
        if (iStart && !iDone) begin
            if (cnt == '1) errSet  = 1'b1;
            else           cntNext = cnt + 1'b1;
        end else if (iDone && !iStart) begin
            if (cnt == '0) errSet  = 1'b1;
            else           cntNext = cnt - 1'b1;
        end
    end

    always_comb begin
        stateNext  = state;
        loadShadow = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    loadShadow = 1'b1;
                    stateNext  = PEND;
                end
            end
            PEND: begin
                if (commit) begin
                    if (transfer) loadShadow = 1'b1;
                    else          stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef BWS_CLIP_EN
    localparam logic signed [WD-1:0] CLIP_HI = WD'(CLIP);
    localparam logic signed [WD-1:0] CLIP_LO = WD'(-CLIP);

    logic signed [WD-1:0] wordIn;

    // Weights saturate on their way into the active bank; biases are copied as-is.
    always_comb begin
        commitBank = shadowBank;
        wordIn     = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            wordIn = $signed(shadowBank[i*WD +: WD]);
            if (wordIn > CLIP_HI)      commitBank[i*WD +: WD] = CLIP_HI;
            else if (wordIn < CLIP_LO) commitBank[i*WD +: WD] = CLIP_LO;
        end
    end
`else
    assign commitBank = shadowBank;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            shadowBank <= '0;
            activeBank <= '0;
            cnt        <= '0;
            version    <= '0;
            err        <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (errSet)     err        <= 1'b1;
            if (loadShadow) shadowBank <= iData_AS;
            if (commit) begin
                activeBank <= commitBank;
                version    <= version + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bias_weight_store.sv
// Scoreboard bench for bias_weight_store: accepted beats queue their expected bank and
// version; a monitor checks each commit when oVersion moves.
module tb_bias_weight_store;

    localparam int NP = 4;
    localparam int NC = 4;
    localparam int WD = 8;
    localparam int WS = 3;
    localparam int WV = 8;
    localparam int PW = NC*NP*WD + NC*WD;

    typedef struct {
        logic [PW-1:0] p;
        logic [WV-1:0] v;
    } exp_t;

    logic          clk = 1'b0;
    logic          iRST = 1'b1;
    logic          iMode = 1'b1;
    logic          iValid = 1'b0;
    logic          oReady;
    logic [PW-1:0] iData = '0;
    logic          iStart = 1'b0;
    logic          iDone = 1'b0;
    logic [PW-1:0] oParam;
    logic [WV-1:0] oVersion;
    logic          oErr;

    int            nTests = 0;
    int            nFail = 0;
    exp_t          sbq[$];
    logic [WV-1:0] expVer = '0;
    logic [WV-1:0] prevVer = '0;

    bias_weight_store #(.NP(NP), .NC(NC), .WD(WD), .WS(WS), .WV(WV), .CLIP(100)) dut (
        .iCLK(clk), .iRST(iRST), .iMode(iMode),
        .iValid_AS(iValid), .oReady_AS(oReady), .iData_AS(iData),
        .iStart(iStart), .iDone(iDone),
        .oParam(oParam), .oVersion(oVersion), .oErr(oErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [7:0] w, input logic [7:0] b);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NC*NP; i++) r[i*WD +: WD] = w;
        for (int c = 0; c < NC; c++) r[NC*NP*WD + c*WD +: WD] = b;
        return r;
    endfunction

    // Monitor: every change of oVersion is one commit to compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (iRST) begin
            prevVer = '0;
        end else if (oVersion != prevVer) begin
            if (sbq.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpected_commit act=%0d req=none", oVersion);
            end else begin
                e = sbq.pop_front();
                chk("sb_param", oParam, e.p);
                chk("sb_version", PW'(oVersion), PW'(e.v));
            end
            prevVer = oVersion;
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        iRST = 1'b1;
        iValid = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", PW'(oReady), PW'(1'b0));
        @(posedge clk); #1;
        iValid = 1'b0;
        sbq.delete();
        expVer = '0;
        @(posedge clk); #1;
        iRST = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [PW-1:0] d, input logic [PW-1:0] expd);
        bit ok;
        ok = 1'b0;
        iValid = 1'b1;
        iData = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (oReady) begin
                expVer = expVer + 1'b1;
                sbq.push_back('{expd, expVer});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nTests++;
            nFail++;
            $display("FAIL send_timeout act=ready_low req=ready_high");
        end
        @(posedge clk); #1;
        iValid = 1'b0;
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
    endtask

    task automatic pulseDone();
        iDone = 1'b1;
        @(posedge clk); #1;
        iDone = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] b1, bA, bC, bD, bG, bH, d6, e6;
        b1 = mk(8'h05, 8'h01);
        bA = mk(8'h11, 8'hA0);
        bC = mk(8'h22, 8'hB1);
        bD = mk(8'hDE, 8'h3C);
        bG = mk(8'h47, 8'h12);
        bH = mk(8'h9A, 8'h5B);

        // Reset state
        doReset();
        @(negedge clk);
        chk("rst_param", oParam, '0);
        chk("rst_version", PW'(oVersion), '0);
        chk("rst_err", PW'(oErr), '0);
        chk("rst_ready", PW'(oReady), PW'(1'b1));

        // 1: single beat with nothing in flight commits one edge after transfer
        @(posedge clk); #1;
        send(b1, b1);
        @(negedge clk);
        chk("t1_param_old", oParam, '0);
        @(negedge clk);
        chk("t1_param_new", oParam, b1);
        chk("t1_version", PW'(oVersion), PW'(8'd1));

        // 2: sample in flight holds the old bank until done
        @(posedge clk); #1;
        pulseStart();
        send(bA, bA);
        @(negedge clk);
        chk("t2_ready_pend", PW'(oReady), PW'(1'b0));
        chk("t2_hold0", oParam, b1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_hold1", oParam, b1);
        @(posedge clk); #1;
        pulseDone();
        @(negedge clk);
        chk("t2_hold_done_edge", oParam, b1);
        @(negedge clk);
        chk("t2_param_new", oParam, bA);
        chk("t2_version", PW'(oVersion), PW'(8'd2));

        // 3: back-to-back beats commit on consecutive edges
        @(posedge clk); #1;
        iValid = 1'b1;
        iData = bC;
        @(negedge clk);
        chk("t3_ready_c", PW'(oReady), PW'(1'b1));
        expVer = expVer + 1'b1;
        sbq.push_back('{bC, expVer});
        @(posedge clk); #1;
        iData = bD;
        @(negedge clk);
        chk("t3_ready_d", PW'(oReady), PW'(1'b1));
        chk("t3_param_a", oParam, bA);
        expVer = expVer + 1'b1;
        sbq.push_back('{bD, expVer});
        @(posedge clk); #1;
        iValid = 1'b0;
        @(negedge clk);
        chk("t3_param_c", oParam, bC);
        @(negedge clk);
        chk("t3_param_d", oParam, bD);
        chk("t3_version", PW'(oVersion), PW'(8'd4));

        // 4a: done with nothing in flight flags error, count stays zero
        @(posedge clk); #1;
        pulseDone();
        @(negedge clk);
        chk("t4_err_underflow", PW'(oErr), PW'(1'b1));
        @(posedge clk); #1;
        send(bG, bG);
        @(negedge clk);
        @(negedge clk);
        chk("t4_cnt_zero_commit", oParam, bG);

        // 4b: eighth start saturates the counter
        doReset();
        @(negedge clk);
        chk("t4_err_cleared", PW'(oErr), '0);
        @(posedge clk); #1;
        iStart = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_err_after7", PW'(oErr), '0);
        @(posedge clk); #1;
        iStart = 1'b0;
        @(negedge clk);
        chk("t4_err_overflow", PW'(oErr), PW'(1'b1));
        @(posedge clk); #1;
        iDone = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        iDone = 1'b0;
        send(bG, bG);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_one_left_hold", oParam, '0);
        chk("t4_one_left_ready", PW'(oReady), PW'(1'b0));
        @(posedge clk); #1;
        pulseDone();
        @(negedge clk);
        chk("t4_last_done_hold", oParam, '0);
        @(negedge clk);
        chk("t4_commit", oParam, bG);

        // 5: inference mode refuses beats; a pending commit still lands
        @(posedge clk); #1;
        iMode = 1'b0;
        iValid = 1'b1;
        iData = mk(8'h33, 8'h44);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_ready_low", PW'(oReady), PW'(1'b0));
        end
        chk("t5_param_kept", oParam, bG);
        @(posedge clk); #1;
        iValid = 1'b0;
        iMode = 1'b1;
        pulseStart();
        send(bH, bH);
        iMode = 1'b0;
        pulseDone();
        @(negedge clk);
        chk("t5_pend_hold", oParam, bG);
        @(negedge clk);
        chk("t5_pend_commit", oParam, bH);
        iMode = 1'b1;

        // 6: weight saturation (CLIP=100) with macro; bit-exact otherwise
        d6 = mk(8'h05, 8'h7F);
        d6[0 +: 8] = 8'h7F;
        d6[8 +: 8] = 8'h80;
        e6 = d6;
`ifdef BWS_CLIP_EN
        e6[0 +: 8] = 8'h64;
        e6[8 +: 8] = 8'h9C;
`endif
        @(posedge clk); #1;
        send(d6, e6);
        @(negedge clk);
        @(negedge clk);
        chk("t6_param", oParam, e6);
        chk("t6_w0", PW'(oParam[0 +: 8]), PW'(e6[0 +: 8]));
        chk("t6_w1", PW'(oParam[8 +: 8]), PW'(e6[8 +: 8]));
        chk("t6_bias", PW'(oParam[PW-WD +: WD]), PW'(8'h7F));

        repeat (3) @(negedge clk);
        chk("sb_drain", PW'(sbq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
